// File: rtl/glitch_sched.sv
// Clock-glitch sequencer: arm, wait for a trigger edge, delay, then emit repeated select pulses.
// Optional ARMED timeout is compiled in with GLITCH_TIMEOUT_EN.
module glitch_sched #(
    parameter int unsigned DLY_W   = 16,
    parameter int unsigned WID_W   = 8,
    parameter int unsigned REP_W   = 4,
    parameter int unsigned TMO_CYC = 65535
) (
    input  logic             clk_in1,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [WID_W-1:0] cfg_width,
    input  logic [DLY_W-1:0] cfg_gap,
    input  logic [REP_W-1:0] cfg_repeat,
    output logic             glitch_sel,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] glitch_count,
    output logic             timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_DELAY, S_GLITCH, S_GAP, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             trig_q;
    logic             edge_c;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] rem_q, rem_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [WID_W-1:0] wid_q, wid_d;
    logic [DLY_W-1:0] gap_q, gap_d;
    logic             sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [REP_W-1:0] count_q, count_d;

`ifdef GLITCH_TIMEOUT_EN
    localparam int unsigned TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    logic [TMO_W-1:0] tcnt_q, tcnt_d;
    logic             tmo_q, tmo_d;
`endif

    assign edge_c = trigger & ~trig_q;

    // Next-state and next-output decode; every output is taken from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dly_d   = dly_q;
        wid_d   = wid_q;
        gap_d   = gap_q;
        sel_d   = 1'b0;
        done_d  = 1'b0;
        count_d = count_q;
`ifdef GLITCH_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_ARMED;
                    dly_d   = cfg_delay;
                    wid_d   = (cfg_width == '0) ? WID_W'(1) : cfg_width;
                    gap_d   = (cfg_gap == '0) ? DLY_W'(1) : cfg_gap;
                    rem_d   = (cfg_repeat == '0) ? REP_W'(1) : cfg_repeat;
                    count_d = '0;
`ifdef GLITCH_TIMEOUT_EN
                    tcnt_d  = '0;
                    tmo_d   = 1'b0;
`endif
                end
            end
            S_ARMED: begin
                if (edge_c) begin
                    if (dly_q == '0) begin
                        state_d = S_GLITCH;
                        cnt_d   = DLY_W'(wid_q);
                        sel_d   = 1'b1;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = dly_q;
                    end
                end
`ifdef GLITCH_TIMEOUT_EN
                else if (tcnt_q == TMO_W'(TMO_CYC - 1)) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TMO_W'(1);
                end
`endif
            end
            S_DELAY: begin
                if (cnt_q == DLY_W'(1)) begin
                    state_d = S_GLITCH;
                    cnt_d   = DLY_W'(wid_q);
                    sel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            S_GLITCH: begin
                if (cnt_q == DLY_W'(1)) begin
                    count_d = (count_q == '1) ? count_q : count_q + REP_W'(1);
                    if (rem_q == REP_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        rem_d   = rem_q - REP_W'(1);
                        cnt_d   = gap_q;
                    end
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                    sel_d = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == DLY_W'(1)) begin
                    state_d = S_GLITCH;
                    cnt_d   = DLY_W'(wid_q);
                    sel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything decoded above; count and latched config hold.
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q;
            rem_d   = rem_q;
            dly_d   = dly_q;
            wid_d   = wid_q;
            gap_d   = gap_q;
            sel_d   = 1'b0;
            done_d  = 1'b0;
            count_d = count_q;
`ifdef GLITCH_TIMEOUT_EN
            tcnt_d  = tcnt_q;
            tmo_d   = tmo_q;
`endif
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_DELAY) ||
                 (state_d == S_GLITCH) || (state_d == S_GAP);
    end

    always_ff @(posedge clk_in1) begin
        if (rst) begin
            state_q <= S_IDLE;
            trig_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            dly_q   <= '0;
            wid_q   <= '0;
            gap_q   <= '0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            trig_q  <= trigger;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dly_q   <= dly_d;
            wid_q   <= wid_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

`ifdef GLITCH_TIMEOUT_EN
    always_ff @(posedge clk_in1) begin
        if (rst) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^(32'(TMO_CYC));
    assign timeout    = 1'b0;
`endif

    assign glitch_sel   = sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign glitch_count = count_q;

endmodule

// File: tb/tb_glitch_sched.sv
// Self-checking bench for glitch_sched: directed cases plus randomized sequences
// checked each cycle against an arithmetic pulse-schedule model.
module tb_glitch_sched;

`ifdef GLITCH_TIMEOUT_EN
    localparam int unsigned TMO = 100;
`else
    localparam int unsigned TMO = 65535;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        abort;
    logic        trigger;
    logic [15:0] cfg_delay;
    logic [7:0]  cfg_width;
    logic [15:0] cfg_gap;
    logic [3:0]  cfg_repeat;
    logic        glitch_sel;
    logic        busy;
    logic        done;
    logic [3:0]  glitch_count;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int cur_n  = 0;

    glitch_sched #(
        .DLY_W(16), .WID_W(8), .REP_W(4), .TMO_CYC(TMO)
    ) dut (
        .clk_in1(clk), .rst(rst), .arm(arm), .abort(abort), .trigger(trigger),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
        .cfg_repeat(cfg_repeat), .glitch_sel(glitch_sel), .busy(busy), .done(done),
        .glitch_count(glitch_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cur_n, obs, exp);
        end
    endtask

    // Schedule model: pulse k spans [T+1+D+k*(W+G), T+D+k*(W+G)+W].
    function automatic bit exp_sel(int n, int t0, int d, int w, int g, int r);
        for (int k = 0; k < r; k++) begin
            int s = t0 + 1 + d + k * (w + g);
            if (n >= s && n <= s + w - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int exp_cnt(int n, int t0, int d, int w, int g, int r);
        int c = 0;
        for (int k = 0; k < r; k++)
            if (n >= t0 + d + k * (w + g) + w + 1) c++;
        return c;
    endfunction

    // Arm in cycle 0, trigger edge in cycle 1+p held for h cycles; optional noise on
    // arm/cfg/trigger while the sequence should ignore it.
    task automatic run_seq(input int d, input int w, input int g, input int r,
                           input int p, input int h, input bit noise);
        int we = (w == 0) ? 1 : w;
        int ge = (g == 0) ? 1 : g;
        int re = (r == 0) ? 1 : r;
        int t0 = 1 + p;
        int le = t0 + d + (re - 1) * (we + ge) + we;
        for (int t = 0; t < le + 3; t++) begin
            abort = 1'b0;
            if (t == 0) begin
                arm        = 1'b1;
                cfg_delay  = 16'(d);
                cfg_width  = 8'(w);
                cfg_gap    = 16'(g);
                cfg_repeat = 4'(r);
            end else begin
                arm = noise && (t <= le) && ($urandom_range(0, 3) == 0);
                if (noise) begin
                    cfg_delay  = 16'($urandom_range(0, 9));
                    cfg_width  = 8'($urandom_range(0, 9));
                    cfg_gap    = 16'($urandom_range(0, 9));
                    cfg_repeat = 4'($urandom_range(0, 9));
                end
            end
            if (t < t0)           trigger = 1'b0;
            else if (t < t0 + h)  trigger = 1'b1;
            else                  trigger = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
            cur_n = t + 1;
            chk("seq_sel",   32'(glitch_sel),   32'(exp_sel(cur_n, t0, d, we, ge, re)));
            chk("seq_busy",  32'(busy),         32'(cur_n >= 1 && cur_n <= le));
            chk("seq_done",  32'(done),         32'(cur_n == le + 1));
            chk("seq_count", 32'(glitch_count), 32'(exp_cnt(cur_n, t0, d, we, ge, re)));
            chk("seq_tmo",   32'(timeout),      32'd0);
        end
        arm     = 1'b0;
        trigger = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
        cfg_delay = '0; cfg_width = '0; cfg_gap = '0; cfg_repeat = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel",   32'(glitch_sel),   32'd0);
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_done",  32'(done),         32'd0);
        chk("rst_count", 32'(glitch_count), 32'd0);
        chk("rst_tmo",   32'(timeout),      32'd0);
        rst = 1'b0;

        // Trigger edges in IDLE do nothing
        for (int t = 0; t < 8; t++) begin
            trigger = t[0];
            @(posedge clk);
            #1;
            chk("idle_trig_sel",  32'(glitch_sel), 32'd0);
            chk("idle_trig_busy", 32'(busy),       32'd0);
        end
        trigger = 1'b0;
        @(posedge clk);
        #1;

        run_seq(3, 2, 0, 1, 2, 1, 1'b0);   // basic
        run_seq(0, 1, 2, 3, 0, 1, 1'b0);   // repeat
        run_seq(0, 0, 0, 0, 1, 1, 1'b0);   // zero cfg
        run_seq(2, 1, 1, 2, 0, 40, 1'b0);  // held-high trigger
        run_seq(5, 1, 1, 2, 1, 2, 1'b1);   // re-arm and cfg churn during DELAY

        // Abort on 2nd cycle of a W=5 pulse
        for (int t = 0; t < 12; t++) begin
            arm        = (t == 0);
            cfg_delay  = 16'd0; cfg_width = 8'd5; cfg_gap = 16'd1; cfg_repeat = 4'd1;
            trigger    = (t == 1);
            abort      = (t == 3);
            @(posedge clk);
            #1;
            cur_n = t + 1;
            chk("abort_sel",   32'(glitch_sel),   32'(cur_n == 2 || cur_n == 3));
            chk("abort_busy",  32'(busy),         32'(cur_n >= 1 && cur_n <= 3));
            chk("abort_done",  32'(done),         32'd0);
            chk("abort_count", 32'(glitch_count), 32'd0);
        end
        arm = 1'b0; abort = 1'b0; trigger = 1'b0;

        // arm+abort together in IDLE: stay IDLE, count holds
        run_seq(0, 1, 1, 2, 0, 1, 1'b0);
        arm = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0; abort = 1'b0;
        chk("armabort_busy",  32'(busy),         32'd0);
        chk("armabort_count", 32'(glitch_count), 32'd2);
        trigger = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("armabort_sel", 32'(glitch_sel), 32'd0);
        trigger = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-pulse
        for (int t = 0; t < 4; t++) begin
            arm       = (t == 0);
            cfg_delay = 16'd0; cfg_width = 8'd4; cfg_repeat = 4'd1;
            trigger   = (t == 1);
            rst       = (t == 3);
            @(posedge clk);
            #1;
            cur_n = t + 1;
            chk("rstmid_sel",   32'(glitch_sel),   32'(cur_n == 2 || cur_n == 3));
            chk("rstmid_busy",  32'(busy),         32'(cur_n <= 3));
            chk("rstmid_count", 32'(glitch_count), 32'd0);
        end
        arm = 1'b0; rst = 1'b0; trigger = 1'b0;
        @(posedge clk);
        #1;

`ifdef GLITCH_TIMEOUT_EN
        // ARMED timeout after TMO cycles, then a re-arm clears it
        for (int t = 0; t < TMO + 4; t++) begin
            arm = (t == 0);
            @(posedge clk);
            #1;
            cur_n = t + 1;
            chk("tmo_busy", 32'(busy),    32'(cur_n <= TMO));
            chk("tmo_flag", 32'(timeout), 32'(cur_n >= TMO + 1));
            chk("tmo_done", 32'(done),    32'd0);
        end
        arm = 1'b0;
        run_seq(1, 1, 1, 1, 0, 1, 1'b0);
`else
        // Long wait in ARMED without timeout
        run_seq(1, 2, 1, 2, 150, 1, 1'b0);
`endif

        // Randomized sequences
        for (int i = 0; i < 30; i++) begin
            run_seq(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), int'($urandom_range(1, 6)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
